// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache clients, the tagged memory port and the arbiter.
// The slave modport is the arbiter's view; master is the view from the clients/memory side.
interface mem_bus_arbiter_if #(
  parameter int XLEN = 32
);
  logic [1:0]      dcache2mem_command;
  logic [XLEN-1:0] dcache2mem_addr;
  logic [63:0]     dcache2mem_data;
  logic [1:0]      icache2mem_command;
  logic [XLEN-1:0] icache2mem_addr;
  logic            icache_squash;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2dcache_response;
  logic [3:0]      mem2icache_response;
  logic [3:0]      mem2dcache_tag;
  logic [3:0]      mem2icache_tag;
  logic [63:0]     mem2client_data;
  logic [4:0]      outstanding_count;
  logic            spurious_tag;

  modport slave (
    input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
    input  icache2mem_command, icache2mem_addr, icache_squash,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2dcache_response, mem2icache_response,
    output mem2dcache_tag, mem2icache_tag, mem2client_data,
    output outstanding_count, spurious_tag
  );

  modport master (
    output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
    output icache2mem_command, icache2mem_addr, icache_squash,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2dcache_response, mem2icache_response,
    input  mem2dcache_tag, mem2icache_tag, mem2client_data,
    input  outstanding_count, spurious_tag
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Icache/dcache arbiter onto the single tagged memory bus, with a per-tag owner table
// that routes returned data back to the issuing client and drops squashed fetches.
module mem_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic             clock,
  input logic             reset,
  mem_bus_arbiter_if.slave bus
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_LIMIT);
  localparam logic [4:0]    OUT_LIMIT  = 5'(MAX_OUTSTANDING);

  logic [15:0]   ent_valid;
  logic [15:0]   ent_icache;
  logic [15:0]   ent_drop;
  logic [15:0]   valid_nxt;
  logic [SW-1:0] starve_cnt;
  logic [4:0]    out_cnt;
  logic          spurious;

  logic          load_ok;
  logic          i_wants;
  logic          d_elig;
  logic          i_elig;
  logic          grant_d;
  logic          grant_i;
  logic          accepted;
  logic          alloc;
  logic [3:0]    ret_tag;
  logic          ret_hit;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int k = 0; k < 16; k++) n = n + {4'd0, v[k]};
    return n;
  endfunction

  // Grant: an icache STORE is not a request; loads are held off once the table is full.
  always_comb begin
    load_ok  = (out_cnt < OUT_LIMIT);
    i_wants  = (bus.icache2mem_command == BUS_LOAD);
    d_elig   = (bus.dcache2mem_command == BUS_STORE) ||
               ((bus.dcache2mem_command == BUS_LOAD) && load_ok);
    i_elig   = i_wants && load_ok;
    grant_i  = i_elig && (!d_elig || (starve_cnt >= STARVE_SAT));
    grant_d  = d_elig && !grant_i;
    accepted = (grant_d || grant_i) && (bus.mem2proc_response != 4'd0);
    alloc    = accepted && (grant_i || (bus.dcache2mem_command == BUS_LOAD));
  end

  always_comb begin
    bus.proc2mem_command    = BUS_NONE;
    bus.proc2mem_addr       = '0;
    bus.proc2mem_data       = '0;
    bus.mem2dcache_response = 4'd0;
    bus.mem2icache_response = 4'd0;
    if (grant_d) begin
      bus.proc2mem_command    = bus.dcache2mem_command;
      bus.proc2mem_addr       = bus.dcache2mem_addr;
      if (bus.dcache2mem_command == BUS_STORE) bus.proc2mem_data = bus.dcache2mem_data;
      bus.mem2dcache_response = bus.mem2proc_response;
    end else if (grant_i) begin
      bus.proc2mem_command    = BUS_LOAD;
      bus.proc2mem_addr       = bus.icache2mem_addr;
      bus.mem2icache_response = bus.mem2proc_response;
    end
  end

  // Return routing reads the pre-edge table, so a tag re-issued this cycle still reaches its old owner.
  always_comb begin
    ret_tag            = bus.mem2proc_tag;
    ret_hit            = (ret_tag != 4'd0) && ent_valid[ret_tag];
    bus.mem2dcache_tag = (ret_hit && !ent_icache[ret_tag]) ? ret_tag : 4'd0;
    bus.mem2icache_tag = (ret_hit && ent_icache[ret_tag] && !ent_drop[ret_tag] &&
                          !bus.icache_squash) ? ret_tag : 4'd0;
    bus.mem2client_data   = bus.mem2proc_data;
    bus.outstanding_count = out_cnt;
    bus.spurious_tag      = spurious;
    valid_nxt = ent_valid;
    if (ret_tag != 4'd0) valid_nxt[ret_tag] = 1'b0;
    if (alloc) valid_nxt[bus.mem2proc_response] = 1'b1;
  end

  // Owner-table state update at the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid  <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
      spurious   <= 1'b0;
    end else begin
      ent_valid <= valid_nxt;
      out_cnt   <= popcount16(valid_nxt);
      if (ret_tag != 4'd0 && !ent_valid[ret_tag]) spurious <= 1'b1;
      if (accepted && grant_i) begin
        starve_cnt <= '0;
      end else if (accepted && grant_d && i_wants && (starve_cnt < STARVE_SAT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Owner/drop bits are only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (bus.icache_squash) ent_drop <= ent_drop | (ent_valid & ent_icache);
    if (alloc) begin
      ent_icache[bus.mem2proc_response] <= grant_i;
      ent_drop[bus.mem2proc_response]   <= grant_i && bus.icache_squash;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios followed by randomized traffic,
// with expectations produced by a tag-ownership model and checked by an independent monitor.
module tb_mem_bus_arbiter;
  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_OUT      = 8;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LD   = 2'd1;
  localparam logic [1:0] ST   = 2'd2;

  typedef struct packed {
    logic [1:0]      cmd;
    logic [XLEN-1:0] addr;
    logic [63:0]     data;
    logic [3:0]      dresp;
    logic [3:0]      iresp;
    logic [3:0]      dtag;
    logic [3:0]      itag;
    logic [63:0]     cdata;
    logic [4:0]      cnt;
    logic            spur;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  exp_t mon_e;

  // Reference model: own[t] 0=free, 1=dcache, 2=icache, 3=icache but squashed
  int   own[16];
  int   starve;
  bit   spur_m;

  always #5 clock = ~clock;

  mem_bus_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_bus_arbiter #(
    .XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int t = 1; t < 16; t++) if (own[t] != 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 16; t++) own[t] = 0;
    starve = 0;
    spur_m = 1'b0;
  endtask

  task automatic drive_idle();
    bus.dcache2mem_command = NONE;
    bus.dcache2mem_addr    = '0;
    bus.dcache2mem_data    = '0;
    bus.icache2mem_command = NONE;
    bus.icache2mem_addr    = '0;
    bus.icache_squash      = 1'b0;
    bus.mem2proc_response  = 4'd0;
    bus.mem2proc_data      = '0;
    bus.mem2proc_tag       = 4'd0;
  endtask

  task automatic step(input logic [1:0] dc, input logic [XLEN-1:0] da, input logic [63:0] dd,
                      input logic [1:0] ic, input logic [XLEN-1:0] ia, input logic sq,
                      input logic [3:0] resp, input logic [3:0] tag);
    exp_t        e;
    int          cnt;
    int          who;
    bit          d_ok;
    bit          i_ok;
    logic [63:0] md;
    md = {$urandom, $urandom};
    @(posedge clock);
    #1;
    bus.dcache2mem_command = dc;
    bus.dcache2mem_addr    = da;
    bus.dcache2mem_data    = dd;
    bus.icache2mem_command = ic;
    bus.icache2mem_addr    = ia;
    bus.icache_squash      = sq;
    bus.mem2proc_response  = resp;
    bus.mem2proc_data      = md;
    bus.mem2proc_tag       = tag;
    cnt  = model_count();
    d_ok = (dc == ST) || (dc == LD && cnt < MAX_OUT);
    i_ok = (ic == LD) && (cnt < MAX_OUT);
    if (i_ok && (!d_ok || starve >= STARVE_LIMIT)) who = 2;
    else if (d_ok) who = 1;
    else who = 0;
    e = '0;
    if (who == 1) begin
      e.cmd   = dc;
      e.addr  = da;
      e.data  = (dc == ST) ? dd : 64'd0;
      e.dresp = resp;
    end else if (who == 2) begin
      e.cmd   = LD;
      e.addr  = ia;
      e.iresp = resp;
    end
    if (tag != 4'd0) begin
      if (own[tag] == 1) e.dtag = tag;
      else if (own[tag] == 2 && !sq) e.itag = tag;
    end
    e.cdata = md;
    e.cnt   = 5'(cnt);
    e.spur  = spur_m;
    sbq.push_back(e);
    // What the coming clock edge does to the table
    if (tag != 4'd0) begin
      if (own[tag] == 0) spur_m = 1'b1;
      own[tag] = 0;
    end
    if (sq) for (int t = 1; t < 16; t++) if (own[t] == 2) own[t] = 3;
    if (who != 0 && resp != 4'd0) begin
      if (who == 2) starve = 0;
      else if (ic == LD && starve < STARVE_LIMIT) starve++;
      if (e.cmd == LD) own[resp] = (who == 1) ? 1 : (sq ? 3 : 2);
    end
  endtask

  task automatic idle_step(input logic [3:0] tag);
    step(NONE, '0, '0, NONE, '0, 1'b0, 4'd0, tag);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clock);
    #2;
    drive_idle();
    reset = 1'b0;
    #1;
    chk({nm, " count"}, 64'(bus.outstanding_count), 64'd0);
    chk({nm, " spurious"}, 64'(bus.spurious_tag), 64'd0);
    model_clear();
    @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clock) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk("cmd",   64'(bus.proc2mem_command),    64'(mon_e.cmd));
      chk("addr",  64'(bus.proc2mem_addr),       64'(mon_e.addr));
      chk("data",  bus.proc2mem_data,            mon_e.data);
      chk("dresp", 64'(bus.mem2dcache_response), 64'(mon_e.dresp));
      chk("iresp", 64'(bus.mem2icache_response), 64'(mon_e.iresp));
      chk("dtag",  64'(bus.mem2dcache_tag),      64'(mon_e.dtag));
      chk("itag",  64'(bus.mem2icache_tag),      64'(mon_e.itag));
      chk("cdata", bus.mem2client_data,          mon_e.cdata);
      chk("count", 64'(bus.outstanding_count),   64'(mon_e.cnt));
      chk("spur",  64'(bus.spurious_tag),        64'(mon_e.spur));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  dc;
    logic [1:0]  ic;
    logic        sq;
    logic [3:0]  resp;
    logic [3:0]  tag;
    int          r;
    int          live[$];
    drive_idle();
    model_clear();
    do_reset("init");

    // dcache beats icache by default; tag 3 comes back to the dcache
    step(LD, 32'h100, '0, LD, 32'h200, 1'b0, 4'd3, 4'd0);
    #1;
    chk("t1 addr", 64'(bus.proc2mem_addr), 64'h100);
    chk("t1 dresp", 64'(bus.mem2dcache_response), 64'd3);
    chk("t1 iresp", 64'(bus.mem2icache_response), 64'd0);
    idle_step(4'd3);
    #1;
    chk("t1 count", 64'(bus.outstanding_count), 64'd1);
    chk("t1 dtag", 64'(bus.mem2dcache_tag), 64'd3);
    idle_step(4'd0);
    #1;
    chk("t1 count after", 64'(bus.outstanding_count), 64'd0);

    // Starvation: four losses, then the icache is forced through
    do_reset("t2");
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      step(ST, 32'h300 + 32'(k * 8), {$urandom, $urandom}, LD, 32'h400, 1'b0, 4'd1, 4'd0);
      #1;
      chk("t2 store wins", 64'(bus.proc2mem_command), 64'(ST));
    end
    step(ST, 32'h320, 64'h55, LD, 32'h400, 1'b0, 4'd6, 4'd0);
    #1;
    chk("t2 forced cmd", 64'(bus.proc2mem_command), 64'(LD));
    chk("t2 forced addr", 64'(bus.proc2mem_addr), 64'h400);
    chk("t2 forced iresp", 64'(bus.mem2icache_response), 64'd6);
    step(ST, 32'h500, 64'h66, LD, 32'h404, 1'b0, 4'd2, 4'd6);
    #1;
    chk("t2 starve cleared", 64'(bus.proc2mem_command), 64'(ST));
    chk("t2 itag", 64'(bus.mem2icache_tag), 64'd6);

    // Outstanding limit blocks loads but not stores
    do_reset("t3");
    for (int t = 1; t <= MAX_OUT; t++)
      step(LD, 32'(t * 16), '0, NONE, '0, 1'b0, 4'(t), 4'd0);
    step(LD, 32'h900, '0, NONE, '0, 1'b0, 4'd9, 4'd0);
    #1;
    chk("t3 full cmd", 64'(bus.proc2mem_command), 64'(NONE));
    chk("t3 full dresp", 64'(bus.mem2dcache_response), 64'd0);
    chk("t3 full count", 64'(bus.outstanding_count), 64'(MAX_OUT));
    step(ST, 32'h904, 64'hABCD, LD, 32'h908, 1'b0, 4'd9, 4'd0);
    #1;
    chk("t3 store cmd", 64'(bus.proc2mem_command), 64'(ST));
    chk("t3 store dresp", 64'(bus.mem2dcache_response), 64'd9);
    chk("t3 icache blocked", 64'(bus.mem2icache_response), 64'd0);
    idle_step(4'd0);
    #1;
    chk("t3 store unrecorded", 64'(bus.outstanding_count), 64'(MAX_OUT));

    // Squashed fetch is dropped on return but still frees its entry
    do_reset("t4");
    step(NONE, '0, '0, LD, 32'h600, 1'b0, 4'd5, 4'd0);
    step(NONE, '0, '0, NONE, '0, 1'b1, 4'd0, 4'd0);
    idle_step(4'd5);
    #1;
    chk("t4 itag dropped", 64'(bus.mem2icache_tag), 64'd0);
    idle_step(4'd0);
    #1;
    chk("t4 count", 64'(bus.outstanding_count), 64'd0);

    // Spurious tag is sticky; async reset clears it mid-flight
    do_reset("t5");
    idle_step(4'd7);
    for (int k = 0; k < 3; k++) begin
      idle_step(4'd0);
      #1;
      chk("t5 spurious sticky", 64'(bus.spurious_tag), 64'd1);
    end
    step(LD, 32'h700, '0, NONE, '0, 1'b0, 4'd4, 4'd0);
    idle_step(4'd0);
    do_reset("t5 midflight");
    idle_step(4'd4);
    idle_step(4'd0);
    #1;
    chk("t5 discarded tag spurious", 64'(bus.spurious_tag), 64'd1);

    // Same-cycle return and reissue of tag 2
    do_reset("t6");
    step(LD, 32'h800, '0, NONE, '0, 1'b0, 4'd2, 4'd0);
    step(NONE, '0, '0, LD, 32'h804, 1'b0, 4'd2, 4'd2);
    #1;
    chk("t6 old owner dtag", 64'(bus.mem2dcache_tag), 64'd2);
    chk("t6 new owner itag", 64'(bus.mem2icache_tag), 64'd0);
    idle_step(4'd2);
    #1;
    chk("t6 new owner return", 64'(bus.mem2icache_tag), 64'd2);

    // Randomized traffic
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rand midflight");
      dc   = 2'($urandom_range(0, 2));
      ic   = 2'($urandom_range(0, 2));
      sq   = ($urandom_range(0, 7) == 0);
      resp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      live.delete();
      for (int t = 1; t < 16; t++) if (own[t] != 0) live.push_back(t);
      r = $urandom_range(0, 9);
      if (r < 5 && live.size() > 0) tag = 4'(live[$urandom_range(0, live.size() - 1)]);
      else if (r == 5) tag = 4'($urandom_range(1, 15));
      else tag = 4'd0;
      step(dc, $urandom, {$urandom, $urandom}, ic, $urandom, sq, resp, tag);
    end
    idle_step(4'd0);
    @(negedge clock);
    #1;
    chk("scoreboard drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-client arbiter between the instruction cache and the data cache. Drives the processor's single tagged memory bus (proc2mem_*/mem2proc_*) into the unified memory model.
- Grants one request per cycle and tracks outstanding load tags in an owner table. Routes returned data tags to the client that issued the load.
- Supports an instruction-side squash: in-flight fetches are dropped when their data returns.

Parameters:
- XLEN, 32, address width.
- STARVE_LIMIT, 4, number of consecutive icache losses before the icache is force-granted.
- MAX_OUTSTANDING, 8, maximum number of un-returned load tags. At this limit, new loads are blocked.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dcache2mem_command  in  2  BUS_NONE=0 / BUS_LOAD=1 / BUS_STORE=2
- dcache2mem_addr  in  XLEN  dcache request address
- dcache2mem_data  in  64  store data
- icache2mem_command  in  2  BUS_NONE or BUS_LOAD only; BUS_STORE is treated as NONE
- icache2mem_addr  in  XLEN  icache request address
- icache_squash  in  1  drop all currently in-flight icache loads
- mem2proc_response  in  4  nonzero = request accepted with this tag; 0 = rejected
- mem2proc_data  in  64  returned data
- mem2proc_tag  in  4  nonzero = data for this tag is valid this cycle
- proc2mem_command  out  2  granted command
- proc2mem_addr  out  XLEN  granted address
- proc2mem_data  out  64  granted store data (0 for loads)
- mem2dcache_response  out  4  mem2proc_response if dcache was granted, else 0
- mem2icache_response  out  4  mem2proc_response if icache was granted, else 0
- mem2dcache_tag  out  4  returned tag when owner is dcache, else 0
- mem2icache_tag  out  4  returned tag when owner is icache and not dropped, else 0
- mem2client_data  out  64  mem2proc_data, passed through
- outstanding_count  out  5  number of valid owner-table entries
- spurious_tag  out  1  sticky flag: a tag returned with no valid owner

Behaviour:
- Reset (reset==0, asynchronous):
  - All owner entries invalid; starve counter = 0; spurious_tag = 0.
  - Combinational outputs follow from the cleared state.
  - A reset mid-transaction discards all in-flight ownership. Later tag returns then set spurious_tag.
- Grant (combinational, same cycle):
  - Default priority is dcache over icache.
  - The icache wins if it requests and starve_cnt >= STARVE_LIMIT.
  - A load is eligible only if outstanding_count < MAX_OUTSTANDING. Stores are always eligible.
  - An ineligible load is not granted, its response reads 0, and the other client may be granted instead.
  - No grant: proc2mem_command=BUS_NONE, addr=0, data=0.
- Response routing: the mem2proc_response value goes only to the granted client, in the same cycle. The other client sees 0 and must hold and retry.
- Accept: granted BUS_LOAD with response != 0 → at posedge, entry[response] <= {valid=1, owner=granted, drop=0}. Stores are never recorded.
- Return: mem2proc_tag != 0 and entry valid:
  - Forward the tag to the owner's tag port in the same cycle; the icache port stays 0 if drop=1.
  - The entry is cleared at posedge.
  - mem2proc_tag != 0 with the entry invalid → spurious_tag <= 1; nothing is forwarded.
- Same-cycle accept and return of the same tag: forwarding uses the old entry; the new set wins at posedge.
- Squash: icache_squash=1 sets drop=1 on every valid icache entry at posedge.
  - Applies to entries that are valid during the squash cycle, and to an icache load accepted in that same cycle.
  - A return in the squash cycle is already suppressed (mem2icache_tag=0).
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when the icache requests, dcache is granted, and the grant is accepted.
  - Resets to 0 when an icache grant is accepted.
  - Otherwise holds.
- outstanding_count is the population count of valid entries, registered. Only entries 1..15 are used; tag 0 never allocates.

Test Plan:
- Reset, then dcache LOAD 0x100 with icache LOAD 0x200, mem response 3 → proc2mem_addr=0x100, mem2dcache_response=3, mem2icache_response=0. Next cycle outstanding_count=1; mem2proc_tag=3 → mem2dcache_tag=3; count returns to 0.
- dcache streams stores continuously while icache holds a LOAD, mem always accepts → icache is granted on the 5th cycle (after 4 losses); the starve counter then resets to 0.
- Issue 8 accepted loads with no returns → 9th dcache LOAD: proc2mem_command=NONE, response 0. A concurrent dcache STORE is still granted.
- icache LOAD accepted with tag 5, squash next cycle, then mem2proc_tag=5 → mem2icache_tag=0, entry freed, outstanding_count=0.
- mem2proc_tag=7 with no outstanding entry → spurious_tag=1 and it stays 1 until reset. Pulling reset low mid-flight clears count and flag asynchronously.
- Tag 2 returns while a new load accepted in the same cycle is issued tag 2 → old owner receives tag 2; entry 2 is valid afterwards with the new owner.
